// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle valid/frame_err strobes.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);
  // Stop bit is sampled one cycle early so the FSM is idle well before the next start edge.
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;

  // Next-state, datapath and strobe generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    rx_meta_d   = uart_in;
    rx_s_d      = rx_meta_q;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[bit_idx_q] = rx_s_q;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial line driver, output monitor and a byte-level expectation model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB    = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;
  localparam int LAT    = 9 * CPB + (CPB - 1) / 2 + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_in = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] vq[$];
  int         vt[$];
  int         fe_cnt = 0;
  int         both_cnt = 0;
  int         busy_cyc = 0;
  logic [7:0] exp_data = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #(CLK_NS / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor on the inactive edge
  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(data);
      vt.push_back(cyc);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (valid && frame_err) both_cnt <= both_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int period_ns);
    uart_in = 1'b0;
    #(period_ns);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      #(period_ns);
    end
    uart_in = stop_ok;
    #(period_ns);
    uart_in = 1'b1;
  endtask

  task automatic expect_good(input string name, input logic [7:0] b, input int period_ns);
    int v0, f0;
    v0 = vq.size();
    f0 = fe_cnt;
    align();
    send_frame(b, 1'b1, period_ns);
    idle(2 * CPB);
    exp_data = b;
    vectors++;
    if (vq.size() - v0 !== 1) begin
      miscompares++;
      $display("FAIL %s_valid_count: got %0d want 1", name, vq.size() - v0);
    end
    vectors++;
    if (data !== exp_data) begin
      miscompares++;
      $display("FAIL %s_data: got %02h want %02h", name, data, exp_data);
    end
    vectors++;
    if (fe_cnt - f0 !== 0) begin
      miscompares++;
      $display("FAIL %s_frame_err: got %0d want 0", name, fe_cnt - f0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_in = 1'b1;
    idle(4);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %02h want 00", data); end
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int v0, f0, b0, start, lat, bc;
    v0 = vq.size();
    f0 = fe_cnt;
    b0 = busy_cyc;
    align();
    start = cyc;
    send_frame(8'hA5, 1'b1, BIT_NS);
    idle(2 * CPB);
    exp_data = 8'hA5;
    vectors++;
    if (vq.size() - v0 !== 1) begin
      miscompares++;
      $display("FAIL a5_valid_count: got %0d want 1", vq.size() - v0);
    end
    if (vq.size() > v0) begin
      vectors++;
      if (vq[v0] !== 8'hA5) begin miscompares++; $display("FAIL a5_data_at_valid: got %02h want a5", vq[v0]); end
      lat = vt[v0] - start;
      vectors++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        miscompares++;
        $display("FAIL a5_latency: got %0d want %0d..%0d", lat, LAT - 1, LAT + 1);
      end
    end
    vectors++;
    if (fe_cnt - f0 !== 0) begin miscompares++; $display("FAIL a5_frame_err: got %0d want 0", fe_cnt - f0); end
    bc = busy_cyc - b0;
    vectors++;
    if (bc < 148 || bc > 156) begin miscompares++; $display("FAIL a5_busy_cycles: got %0d want 148..156", bc); end
    vectors++;
    if (data !== exp_data) begin miscompares++; $display("FAIL a5_data: got %02h want %02h", data, exp_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int v0;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    v0 = vq.size();
    align();
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, BIT_NS);
    idle(2 * CPB);
    exp_data = 8'h3C;
    vectors++;
    if (vq.size() - v0 !== 3) begin
      miscompares++;
      $display("FAIL b2b_valid_count: got %0d want 3", vq.size() - v0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (vq[v0 + i] !== bytes[i]) begin
          miscompares++;
          $display("FAIL b2b_data%0d: got %02h want %02h", i, vq[v0 + i], bytes[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (vt[v0 + i] - vt[v0 + i - 1] !== 10 * CPB) begin
          miscompares++;
          $display("FAIL b2b_spacing%0d: got %0d want %0d", i, vt[v0 + i] - vt[v0 + i - 1], 10 * CPB);
        end
      end
    end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = vq.size();
    f0 = fe_cnt;
    align();
    send_frame(8'h5A, 1'b0, BIT_NS);
    idle(3 * CPB);
    vectors++;
    if (fe_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - f0); end
    vectors++;
    if (vq.size() - v0 !== 0) begin miscompares++; $display("FAIL ferr_valid: got %0d want 0", vq.size() - v0); end
    vectors++;
    if (data !== exp_data) begin miscompares++; $display("FAIL ferr_data_kept: got %02h want %02h", data, exp_data); end
    expect_good("after_ferr_81", 8'h81, BIT_NS);
  endtask

  task automatic test_glitch();
    int v0, f0;
    bit seen_busy, cleared;
    v0 = vq.size();
    f0 = fe_cnt;
    seen_busy = 1'b0;
    cleared = 1'b0;
    align();
    uart_in = 1'b0;
    #(3 * CLK_NS);
    uart_in = 1'b1;
    for (int k = 0; k < 12 && !cleared; k++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) cleared = 1'b1;
    end
    vectors++;
    if (seen_busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_seen: got %b want 1", seen_busy); end
    vectors++;
    if (cleared !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_clear: got %b want 1 within 12 cycles", cleared); end
    idle(2 * CPB);
    vectors++;
    if (vq.size() - v0 !== 0) begin miscompares++; $display("FAIL glitch_valid: got %0d want 0", vq.size() - v0); end
    vectors++;
    if (fe_cnt - f0 !== 0) begin miscompares++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - f0); end
    expect_good("after_glitch_42", 8'h42, BIT_NS);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int v0, f0;
    b = 8'h77;
    v0 = vq.size();
    f0 = fe_cnt;
    align();
    uart_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      uart_in = b[i];
      #(BIT_NS);
    end
    uart_in = b[4];
    #(BIT_NS / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    uart_in = 1'b1;
    exp_data = 8'h00;
    @(negedge clk);
    vectors++;
    if (data !== 8'h00) begin miscompares++; $display("FAIL midrst_data: got %02h want 00", data); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vectors++;
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_flags: got valid=%b frame_err=%b want 0/0", valid, frame_err);
    end
    idle(20 * CPB);
    vectors++;
    if (vq.size() - v0 !== 0 || fe_cnt - f0 !== 0) begin
      miscompares++;
      $display("FAIL midrst_no_flag: got valids=%0d ferrs=%0d want 0/0", vq.size() - v0, fe_cnt - f0);
    end
    expect_good("after_rst_c3", 8'hC3, BIT_NS);
  endtask

  task automatic test_baud_tolerance();
    expect_good("baud_fast_96", 8'h96, BIT_NS - CLK_NS / 2);
    expect_good("baud_slow_96", 8'h96, BIT_NS + CLK_NS / 2);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    bit         ok;
    int         v0, f0, bad, gap;
    v0 = vq.size();
    f0 = fe_cnt;
    bad = 0;
    align();
    for (int n = 0; n < 12; n++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 3);
      send_frame(b, ok, BIT_NS);
      if (ok) begin
        exp_q.push_back(b);
        exp_data = b;
      end else begin
        bad++;
      end
      #(gap * BIT_NS);
    end
    idle(2 * CPB);
    vectors++;
    if (vq.size() - v0 !== exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_valid_count: got %0d want %0d", vq.size() - v0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (vq[v0 + i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand_data%0d: got %02h want %02h", i, vq[v0 + i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (fe_cnt - f0 !== bad) begin miscompares++; $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt - f0, bad); end
    vectors++;
    if (data !== exp_data) begin miscompares++; $display("FAIL rand_data_final: got %02h want %02h", data, exp_data); end
  endtask

  task automatic test_flag_exclusive();
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL flags_together: got %0d cycles with valid and frame_err both high, want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_random();
    test_flag_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
